// File: rtl/alu_seq.sv
// WIDTH-bit ALU with registered, valid/ready-handshaked results.
// Single-cycle slice-style logic/arithmetic ops plus an iterative unsigned shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 zero_q, zero_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;
  logic                 ill_q, ill_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Slice-style operand conditioning shared by every ALU op.
  logic [WIDTH-1:0] in1, in2;
  logic [WIDTH:0]   sum_w;
  logic             add_ovf;

  assign in1     = src1 ^ {WIDTH{alu_ctrl[3]}};
  assign in2     = src2 ^ {WIDTH{alu_ctrl[2]}};
  assign sum_w   = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, alu_ctrl[2]};
  assign add_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_w[WIDTH-1] != in1[WIDTH-1]);

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf, alu_ill;

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_res = in1 & in2;
      4'b0001: alu_res = in1 | in2;
      4'b0010, 4'b0110: begin
        alu_res  = sum_w[WIDTH-1:0];
        alu_cout = sum_w[WIDTH];
        alu_ovf  = add_ovf;
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ add_ovf};
      4'b1100: alu_res = in1 & in2;
      default: alu_ill = 1'b1;
    endcase
  end

  // The multiplier lives in the low half of the accumulator and is consumed as the
  // partial product shifts in from the top, so acc_q[0] is always the current multiplier bit.
  logic [WIDTH:0]       mul_add;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 mul_last;

  assign mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{acc_q[0]}}};
  assign acc_step = {mul_add, acc_q[WIDTH-1:1]};
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mode) begin
            mcand_d = src1;
            acc_d   = {{WIDTH{1'b0}}, src2};
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            cout_d      = alu_cout;
            ovf_d       = alu_ovf;
            ill_d       = alu_ill;
            state_d     = DONE;
          end
        end
      end
      MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_last) begin
          result_d    = acc_step[WIDTH-1:0];
          result_hi_d = acc_step[2*WIDTH-1:WIDTH];
          zero_d      = (acc_step == '0);
          cout_d      = 1'b0;
          ovf_d       = 1'b0;
          ill_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, mode, out_valid, out_ready;
  logic [W-1:0] src1, src2, result, result_hi;
  logic [3:0]   alu_ctrl;
  logic         zero, cout, overflow, illegal;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .alu_ctrl(alu_ctrl), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .cout(cout), .overflow(overflow),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic sovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] ctrl, input logic m);
    exp_t e;
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.lo = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0;
    if (m) begin
      p = {32'b0, a} * {32'b0, b};
      e.lo = p[31:0];
      e.hi = p[63:32];
    end else begin
      case (ctrl)
        4'b0000: e.lo = a & b;
        4'b0001: e.lo = a | b;
        4'b0010: begin
          p = {32'b0, a} + {32'b0, b};
          e.lo = p[31:0];
          e.c  = p[32];
          e.v  = sovf(sa + sb);
        end
        4'b0110: begin
          e.lo = a - b;
          e.c  = (a >= b);
          e.v  = sovf(sa - sb);
        end
        4'b0111: e.lo = (sa < sb) ? 32'd1 : 32'd0;
        4'b1100: e.lo = ~(a | b);
        default: e.ill = 1'b1;
      endcase
    end
    e.z = ({e.hi, e.lo} == 64'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("in_ready_done", 64'(in_ready), 64'd0);
    chk("result", 64'(result), 64'(e.lo));
    chk("result_hi", 64'(result_hi), 64'(e.hi));
    chk("zero", 64'(zero), 64'(e.z));
    chk("cout", 64'(cout), 64'(e.c));
    chk("overflow", 64'(overflow), 64'(e.v));
    chk("illegal", 64'(illegal), 64'(e.ill));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, input logic m, output exp_t e);
    int cyc;
    e = model(a, b, ctrl, m);
    src1 = a; src2 = b; alu_ctrl = ctrl; mode = m; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = $urandom; src2 = $urandom; alu_ctrl = 4'($urandom); mode = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 64'(cyc), m ? 64'd33 : 64'd1);
    check_out(e);
    $display("op a=%h b=%h ctrl=%b mode=%0d -> result=%h hi=%h z=%0d c=%0d v=%0d ill=%0d lat=%0d",
             a, b, ctrl, m, result, result_hi, zero, cout, overflow, illegal, cyc);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    exp_t e, held;
    logic [3:0] ctrl_tab [8];
    logic [31:0] a, b;
    ctrl_tab[0] = 4'b0000; ctrl_tab[1] = 4'b0001; ctrl_tab[2] = 4'b0010; ctrl_tab[3] = 4'b0110;
    ctrl_tab[4] = 4'b0111; ctrl_tab[5] = 4'b1100; ctrl_tab[6] = 4'b0011; ctrl_tab[7] = 4'b1001;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; alu_ctrl = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_hi", 64'(result_hi), 64'd0);
    chk("rst_flags", 64'({zero, cout, overflow, illegal}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed boundary cases.
    issue(32'h7FFFFFFF, 32'h00000001, 4'b0010, 1'b0, e);
    chk("add_ovf_result", 64'(result), 64'h80000000);
    chk("add_ovf_flag", 64'(overflow), 64'd1);
    drain();
    issue(32'd5, 32'd5, 4'b0110, 1'b0, e);
    chk("sub_zero", 64'({zero, cout}), 64'b11);
    drain();
    issue(32'd0, 32'd1, 4'b0110, 1'b0, e);
    chk("sub_neg", 64'({result, cout}), {31'd0, 32'hFFFFFFFF, 1'b0});
    drain();
    issue(32'hFFFFFFFF, 32'd1, 4'b0111, 1'b0, e);
    chk("slt_neg", 64'(result), 64'd1);
    drain();
    issue(32'h7FFFFFFF, 32'h80000000, 4'b0111, 1'b0, e);
    chk("slt_ovf", 64'(result), 64'd0);
    drain();
    issue(32'h0, 32'h0, 4'b0011, 1'b0, e);
    chk("illegal_code", 64'({illegal, result}), {31'd0, 1'b1, 32'd0});
    drain();
    issue(32'hFFFFFFFF, 32'd2, 4'b0000, 1'b1, e);
    chk("mul_max", 64'({result_hi, result}), 64'h00000001_FFFFFFFE);
    drain();
    issue(32'd0, 32'd7, 4'b0000, 1'b1, e);
    chk("mul_zero", 64'(zero), 64'd1);
    drain();
    issue(32'h0, 32'h0, 4'b1100, 1'b0, e);
    chk("nor_zero", 64'(result), 64'hFFFFFFFF);

    // Backpressure: held result must not move while new requests knock.
    held = e;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; src1 = $urandom; src2 = $urandom; alu_ctrl = 4'b0010; mode = 1'b0;
      @(posedge clk); #1;
      check_out(held);
      $display("backpressure cycle %0d result=%h in_ready=%0d", i, result, in_ready);
    end
    src1 = 32'd3; src2 = 32'd4; alu_ctrl = 4'b0010; mode = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_drain_valid", 64'(out_valid), 64'd0);
    chk("bp_drain_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out(model(32'd3, 32'd4, 4'b0010, 1'b0));
    $display("backpressure release result=%h", result);
    drain();

    // Randomized mix, including illegal codes and equal operands.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 3));
      issue(a, b, ctrl_tab[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0), e);
      drain();
    end

    // Reset in the middle of a multiply; result register holds a nonzero value beforehand.
    issue(32'h0, 32'h0, 4'b1100, 1'b0, e);
    drain();
    src1 = 32'h1234; src2 = 32'h5678; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    $display("mid-multiply reset: out_valid=%0d result=%h in_ready=%0d", out_valid, result, in_ready);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
